accum_drain: RTL and testbench

//  Result-drain stage downstream of accum_buf's store-result port. On start it sweeps

---
 rtl/accum_drain.sv | 156 +++++++++++++++
 tb/tb_accum_drain.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accum_drain.sv
// accum_drain: sweeps accum_buf result words, quantises each lane to DATA_W and streams
// the beats out through a small credit-controlled FIFO so backpressure never drops a read.
module accum_drain #(
   parameter int BATCH  = 4,
   parameter int RES_W  = 32,
   parameter int DATA_W = 16,
   parameter int DEPTH  = 256,
   parameter int FIFO_D = 4,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [ADDR_W:0]           len,
   input  logic [4:0]                shamt,
   output logic                      busy,
   output logic                      done,
   output logic                      rd_en,
   output logic [ADDR_W-1:0]         rd_addr,
   input  logic [BATCH*RES_W-1:0]    rd_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [BATCH*DATA_W-1:0]   out_data,
   output logic                      out_last
);

   localparam int PTR_W  = $clog2(FIFO_D);
   localparam int CNT_W  = $clog2(FIFO_D + 1);
   localparam int WORD_W = BATCH * DATA_W;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   localparam logic signed [RES_W-1:0] SAT_HI = {{(RES_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [RES_W-1:0] SAT_LO = {{(RES_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
   localparam logic [DATA_W-1:0]       OUT_HI = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic [DATA_W-1:0]       OUT_LO = {1'b1, {(DATA_W-1){1'b0}}};

   function automatic logic [DATA_W-1:0] quantise(input logic signed [RES_W-1:0] v,
                                                  input logic [4:0] sh);
      logic signed [RES_W-1:0] s;
      s = v >>> sh;
      if (s > SAT_HI)
         quantise = OUT_HI;
      else if (s < SAT_LO)
         quantise = OUT_LO;
      else
         quantise = s[DATA_W-1:0];
   endfunction

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      ptr_inc = (p == PTR_W'(FIFO_D - 1)) ? '0 : p + 1'b1;
   endfunction

   logic [1:0]        state;
   logic [ADDR_W-1:0] last_addr;
   logic [4:0]        shamt_r;
   logic [ADDR_W:0]   len_clamp;
   logic              vld_p1;
   logic              last_p1;
   logic [WORD_W-1:0] q_p1;
   logic [WORD_W:0]   mem [FIFO_D];
   logic [WORD_W:0]   head;
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;
   logic [CNT_W:0]    used;
   logic              push;
   logic              pop;

   assign len_clamp = (len > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : len;

   // stage p0: read issue, gated by FIFO credits (stored beats plus the read in flight)
   assign used  = {1'b0, count} + {{CNT_W{1'b0}}, vld_p1};
   assign rd_en = (state == RUN) && (used < (CNT_W+1)'(FIFO_D));

   // stage p1: rd_data returns, is quantised and pushed into the FIFO on the same edge
   always_comb begin
      q_p1 = '0;
      for (int i = 0; i < BATCH; i++)
         q_p1[i*DATA_W +: DATA_W] = quantise(rd_data[i*RES_W +: RES_W], shamt_r);
   end

   assign push = vld_p1;
   assign pop  = out_valid && out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         rd_addr <= '0;
         vld_p1  <= 1'b0;
         last_p1 <= 1'b0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
      end else begin
         vld_p1  <= rd_en;
         last_p1 <= rd_en && (rd_addr == last_addr);
         if (push)
            wr_ptr <= ptr_inc(wr_ptr);
         if (pop)
            rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         case (state)
            IDLE: begin
               if (start) begin
                  if (len == '0) begin
                     state <= DONE;
                  end else begin
                     state   <= RUN;
                     rd_addr <= '0;
                  end
               end
            end
            RUN: begin
               if (rd_en) begin
                  if (rd_addr == last_addr)
                     state <= DRAIN;
                  else
                     rd_addr <= rd_addr + 1'b1;
               end
            end
            DRAIN: begin
               // leave as the final beat pops so done lands in the following cycle
               if (!vld_p1 && (count == '0 || (count == CNT_W'(1) && pop)))
                  state <= DONE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (state == IDLE && start) begin
         last_addr <= ADDR_W'(len_clamp - 1'b1);
         shamt_r   <= shamt;
      end
      if (push)
         mem[wr_ptr] <= {last_p1, q_p1};
   end

   // stage p2: FIFO head drives the output bus, zeroed whenever nothing is valid
   assign head      = mem[rd_ptr];
   assign out_valid = (count != '0);
   assign out_data  = out_valid ? head[WORD_W-1:0] : '0;
   assign out_last  = out_valid & head[WORD_W];
   assign busy      = (state != IDLE);
   assign done      = (state == DONE);

endmodule

// File: tb/tb_accum_drain.sv
// Bench for accum_drain: emulated accum_buf, arithmetic reference model of the drained
// stream, table of quantiser vectors and hand sequences for length, stall and reset corners.
module tb_accum_drain;
   localparam int BATCH  = 4;
   localparam int RES_W  = 32;
   localparam int DATA_W = 16;
   localparam int DEPTH  = 256;
   localparam int FIFO_D = 4;
   localparam int ADDR_W = 8;
   localparam int WORD_W = BATCH * DATA_W;

   logic                    clk = 1'b0;
   logic                    rst = 1'b1;
   logic                    start = 1'b0;
   logic [ADDR_W:0]         len = '0;
   logic [4:0]              shamt = '0;
   logic                    busy, done, rd_en;
   logic [ADDR_W-1:0]       rd_addr;
   logic [BATCH*RES_W-1:0]  rd_data = '0;
   logic                    out_valid;
   logic                    out_ready = 1'b1;
   logic [WORD_W-1:0]       out_data;
   logic                    out_last;

   accum_drain #(.BATCH(BATCH), .RES_W(RES_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
                 .FIFO_D(FIFO_D), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .start(start), .len(len), .shamt(shamt),
      .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [RES_W-1:0]  v;
      int                sh;
      logic [DATA_W-1:0] q;
   } qvec_t;

   logic [BATCH*RES_W-1:0] mem_buf [DEPTH];
   logic [WORD_W:0]        exp_q [$];
   logic [WORD_W:0]        held, last_beat;
   logic                   held_valid = 1'b0;
   int checks = 0, errors = 0, cyc = 0;
   int issued = 0, popped = 0, exp_addr = 0, beats = 0, done_cnt = 0, done_cyc = 0;
   int last_pop_cyc = 0, first_pop_cyc = 0, rd_en_total = 0, valid_total = 0;
   int last_rd_addr = 0, ready_mode = 0, start_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) if (rd_en) rd_data <= mem_buf[rd_addr];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic logic [DATA_W-1:0] ref_q(input logic [RES_W-1:0] v, input int sh);
      longint s, hi, lo;
      s  = longint'($signed(v));
      s  = s >>> sh;
      hi = (longint'(1) <<< (DATA_W - 1)) - 1;
      lo = -hi - 1;
      if (s > hi) return DATA_W'(hi);
      if (s < lo) return DATA_W'(lo);
      return DATA_W'(s);
   endfunction

   always @(negedge clk) begin
      if (!rst) begin
         if (rd_en) begin
            check("credit", 128'((issued - popped) < FIFO_D), 128'(1));
            check("rd_addr", 128'(rd_addr), 128'(exp_addr));
            exp_addr++;
            issued++;
            rd_en_total++;
            last_rd_addr = int'(rd_addr);
         end
         if (out_valid) begin
            valid_total++;
            if (held_valid) check("stall_hold", 128'({out_last, out_data}), 128'(held));
            if (out_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL extra_beat actual=%0h required=no_beat", {out_last, out_data});
               end else begin
                  check("beat", 128'({out_last, out_data}), 128'(exp_q.pop_front()));
               end
               if (beats == 0) first_pop_cyc = cyc;
               beats++;
               popped++;
               last_pop_cyc = cyc;
               last_beat = {out_last, out_data};
               held_valid = 1'b0;
            end else begin
               held_valid = 1'b1;
               held = {out_last, out_data};
            end
         end else begin
            held_valid = 1'b0;
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      case (ready_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = ~out_ready;
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
   endtask

   task automatic do_start(input int l, input int sh);
      int lc = (l > DEPTH) ? DEPTH : l;
      for (int a = 0; a < lc; a++) begin
         logic [WORD_W:0] e;
         e[WORD_W] = (a == lc - 1);
         for (int i = 0; i < BATCH; i++)
            e[i*DATA_W +: DATA_W] = ref_q(mem_buf[a][i*RES_W +: RES_W], sh);
         exp_q.push_back(e);
      end
      exp_addr  = 0;
      beats     = 0;
      start     = 1'b1;
      len       = (ADDR_W+1)'(l);
      shamt     = 5'(sh);
      start_cyc = cyc;
      tick();
      start     = 1'b0;
   endtask

   task automatic finish_run(input int lc);
      int d0 = done_cnt;
      int n = 0;
      while (done_cnt == d0 && n < lc * 12 + 60) begin
         tick();
         n++;
      end
      check("done_seen", 128'(done_cnt != d0), 128'(1));
      check("busy_after_done", 128'(busy), 128'(0));
      tick();
      check("done_pulse_count", 128'(done_cnt - d0), 128'(1));
      check("queue_drained", 128'(exp_q.size()), 128'(0));
      check("beat_count", 128'(beats), 128'(lc));
      if (lc > 0) check("done_after_last_pop", 128'(done_cyc - last_pop_cyc), 128'(1));
   endtask

   task automatic fill_random();
      for (int a = 0; a < DEPTH; a++)
         for (int i = 0; i < BATCH; i++)
            mem_buf[a][i*RES_W +: RES_W] = $urandom() >> $urandom_range(0, 24);
   endtask

   qvec_t qtab [12];

   initial begin
      int r0, v0, n;
      qtab[0]  = '{32'h0010_0000,  4, 16'h7FFF};
      qtab[1]  = '{32'hFFFF_FFD8,  2, 16'hFFF6};
      qtab[2]  = '{32'h8000_0000,  0, 16'h8000};
      qtab[3]  = '{32'h0000_0064,  0, 16'h0064};
      qtab[4]  = '{32'h0000_7FFF,  0, 16'h7FFF};
      qtab[5]  = '{32'h0000_8000,  0, 16'h7FFF};
      qtab[6]  = '{32'hFFFF_8000,  0, 16'h8000};
      qtab[7]  = '{32'hFFFF_7FFF,  0, 16'h8000};
      qtab[8]  = '{32'hFFFF_FFFF, 31, 16'hFFFF};
      qtab[9]  = '{32'h7FFF_FFFF, 31, 16'h0000};
      qtab[10] = '{32'hFFFF_FFFD,  1, 16'hFFFE};
      qtab[11] = '{32'h0001_2345,  8, 16'h0123};
      fill_random();

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 128'(busy), 128'(0));
      check("rst_done", 128'(done), 128'(0));
      check("rst_rd_en", 128'(rd_en), 128'(0));
      check("rst_rd_addr", 128'(rd_addr), 128'(0));
      check("rst_out_valid", 128'(out_valid), 128'(0));
      check("rst_out_data", 128'(out_data), 128'(0));
      check("rst_out_last", 128'(out_last), 128'(0));
      rst = 1'b0;
      tick();

      // basic drain, ready held high
      for (int a = 0; a < 8; a++)
         for (int i = 0; i < BATCH; i++)
            mem_buf[a][i*RES_W +: RES_W] = RES_W'(a * 16 + i);
      ready_mode = 0;
      r0 = rd_en_total;
      do_start(8, 0);
      finish_run(8);
      check("t1_reads", 128'(rd_en_total - r0), 128'(8));
      check("t1_last_addr", 128'(last_rd_addr), 128'(7));
      check("t1_first_latency", 128'(first_pop_cyc - start_cyc), 128'(3));
      check("t1_back_to_back", 128'(last_pop_cyc - first_pop_cyc), 128'(7));

      // toggling backpressure
      fill_random();
      ready_mode = 1;
      do_start(16, 5);
      finish_run(16);

      // quantiser vectors
      ready_mode = 0;
      for (int k = 0; k < 12; k++) begin
         mem_buf[0] = {BATCH{qtab[k].v}};
         do_start(1, qtab[k].sh);
         finish_run(1);
         check("quant_tbl", 128'(last_beat), 128'({1'b1, {BATCH{qtab[k].q}}}));
      end

      // zero length
      r0 = rd_en_total;
      v0 = valid_total;
      do_start(0, 0);
      check("len0_done", 128'(done), 128'(1));
      check("len0_busy", 128'(busy), 128'(1));
      tick();
      check("len0_done_drop", 128'(done), 128'(0));
      check("len0_idle", 128'(busy), 128'(0));
      check("len0_no_reads", 128'(rd_en_total - r0), 128'(0));
      check("len0_no_beats", 128'(valid_total - v0), 128'(0));

      // full depth and clamped length
      fill_random();
      do_start(256, 3);
      finish_run(256);
      check("full_last_addr", 128'(last_rd_addr), 128'(255));
      ready_mode = 2;
      do_start(300, 9);
      finish_run(256);
      check("clamp_last_addr", 128'(last_rd_addr), 128'(255));

      // random drains
      for (int t = 0; t < 6; t++) begin
         int l = $urandom_range(1, 40);
         fill_random();
         do_start(l, $urandom_range(0, 20));
         finish_run(l);
      end

      // start while busy is ignored
      ready_mode = 1;
      do_start(16, 2);
      repeat (6) tick();
      start = 1'b1;
      len   = 9'd3;
      shamt = 5'd7;
      tick();
      start = 1'b0;
      finish_run(16);

      // reset mid-drain
      ready_mode = 0;
      do_start(16, 1);
      n = 0;
      while (beats < 5 && n < 100) begin
         tick();
         n++;
      end
      check("reach_beat5", 128'(beats >= 5), 128'(1));
      #2 rst = 1'b1;
      #1;
      check("mid_rst_busy", 128'(busy), 128'(0));
      check("mid_rst_rd_en", 128'(rd_en), 128'(0));
      check("mid_rst_rd_addr", 128'(rd_addr), 128'(0));
      check("mid_rst_valid", 128'(out_valid), 128'(0));
      check("mid_rst_data", 128'(out_data), 128'(0));
      check("mid_rst_last", 128'(out_last), 128'(0));
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
      issued = 0;
      popped = 0;
      held_valid = 1'b0;
      v0 = done_cnt;
      repeat (6) tick();
      check("no_done_after_rst", 128'(done_cnt - v0), 128'(0));
      check("idle_after_rst", 128'(busy), 128'(0));
      do_start(4, 0);
      finish_run(4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
